fwd_hazard_unit: RTL

//  Operand-hazard controller for the 5-stage pipeline, directly upstream of the EX-stage 3:1 operand muxes.

---
 rtl/fwd_hazard_unit.sv | 119 +++++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding and load-use stall controller feeding the EX-stage operand muxes.
// Optional FWD_STATS_EN adds saturating stall/forward event counters.
module fwd_hazard_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o
`ifdef FWD_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  fwd_cnt_o
`endif
);

    localparam logic [1:0] SEL_ID  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    if (CNT_W < 1) begin : g_cnt_w_chk
        $error("fwd_hazard_unit: CNT_W must be at least 1");
    end

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
    } ex_slot_t;

    // Past EX only the writer identity matters, so MEM/WB drop the source fields.
    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic [REG_AW-1:0] rd;
    } late_slot_t;

    ex_slot_t   ex_q;
    late_slot_t mem_q;
    late_slot_t wb_q;

    logic ex_wr;
    logic mem_wr;
    logic wb_wr;

    assign ex_wr  = ex_q.valid  & ex_q.regwrite  & (ex_q.rd  != '0);
    assign mem_wr = mem_q.valid & mem_q.regwrite & (mem_q.rd != '0);
    assign wb_wr  = wb_q.valid  & wb_q.regwrite  & (wb_q.rd  != '0);

    assign stall_o = id_valid_i & ~flush_i & ex_wr & ex_q.memread &
                     ((ex_q.rd == id_rs_i) | (ex_q.rd == id_rt_i));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= '{valid: ex_q.valid, regwrite: ex_q.regwrite, rd: ex_q.rd};
            if (flush_i || stall_o) begin
                ex_q <= '0;
            end else begin
                ex_q <= '{valid: id_valid_i, rd: id_rd_i, regwrite: id_regwrite_i,
                          memread: id_memread_i, rs: id_rs_i, rt: id_rt_i};
            end
        end
    end

    // MEM is checked first so the youngest producer wins on a double match.
    always_comb begin
        fwd_a_o = SEL_ID;
        fwd_b_o = SEL_ID;
        if (ex_q.valid) begin
            if (mem_wr && (mem_q.rd == ex_q.rs)) begin
                fwd_a_o = SEL_MEM;
            end else if (wb_wr && (wb_q.rd == ex_q.rs)) begin
                fwd_a_o = SEL_WB;
            end
            if (mem_wr && (mem_q.rd == ex_q.rt)) begin
                fwd_b_o = SEL_MEM;
            end else if (wb_wr && (wb_q.rd == ex_q.rt)) begin
                fwd_b_o = SEL_WB;
            end
        end
    end

`ifdef FWD_STATS_EN
    logic fwd_any;
    assign fwd_any = (fwd_a_o != SEL_ID) | (fwd_b_o != SEL_ID);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
            fwd_cnt_o   <= '0;
        end else begin
            if (stall_o && (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + 1'b1;
            end
            if (fwd_any && (fwd_cnt_o != '1)) begin
                fwd_cnt_o <= fwd_cnt_o + 1'b1;
            end
        end
    end
`endif

endmodule
